// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types and constants for the HI/LO unit.
// Holds the sequencer state enum and the latency counter width.
package hilo_pkg;

    localparam int HILO_CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hilo_state_t;

endpackage

// File: rtl/hilo_regs.sv
// hilo_regs: architectural HI/LO register pair.
// Ports: Clk, Reset (sync, active-high); Hi_we/Lo_we load Wdata into
// Hi/Lo; Prod_we loads the 64-bit Prod as {Hi,Lo}; Hi/Lo outputs.
module hilo_regs (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Hi_we,
    input  logic        Lo_we,
    input  logic        Prod_we,
    input  logic [31:0] Wdata,
    input  logic [63:0] Prod,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Hi <= '0;
            Lo <= '0;
        end else if (Prod_we) begin
            Hi <= Prod[63:32];
            Lo <= Prod[31:0];
        end else begin
            if (Hi_we) Hi <= Wdata;
            if (Lo_we) Lo <= Wdata;
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: owns HI/LO, issues the multiplier start, counts its
// latency, captures the product and stalls HI/LO users meanwhile.
// Ports: Clk, Reset (sync, active-high); Start/Is_signed/Flush and
// Mthi/Mtlo/Wdata/Mfhi/Mflo from execute; Mult_start/Mult_signed to
// and Mult_result from the multiplier; Hi, Lo, Rd_data, Busy, Stall.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int MULT_LATENCY = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Is_signed,
    input  logic        Mthi,
    input  logic        Mtlo,
    input  logic [31:0] Wdata,
    input  logic        Mfhi,
    input  logic        Mflo,
    input  logic        Flush,
    output logic        Mult_start,
    output logic        Mult_signed,
    input  logic [63:0] Mult_result,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic [31:0] Rd_data,
    output logic        Busy,
    output logic        Stall
);

    localparam logic [HILO_CNT_W-1:0] LAT_CNT = HILO_CNT_W'(MULT_LATENCY);
    localparam logic [HILO_CNT_W-1:0] ONE     = HILO_CNT_W'(1);

    hilo_state_t           state;
    logic [HILO_CNT_W-1:0] cnt;

    logic idle;
    logic last;
    logic prod_we;
    logic move_ok;
    logic req;

    assign idle    = (state == IDLE);
    assign last    = (state == BUSY) && (cnt == ONE);
    // A flush in the final cycle still drops the product.
    assign prod_we = last && !Flush;
    // Start beats a simultaneous move, even if the start is flushed.
    assign move_ok = idle && !Start;
    assign req     = Mfhi | Mflo | Mthi | Mtlo | Start;

    assign Mult_start  = idle && Start && !Flush;
    assign Mult_signed = Is_signed;
    assign Busy        = (state == BUSY);
    assign Stall       = Busy && req;
    assign Rd_data     = Mfhi ? Hi : (Mflo ? Lo : 32'h0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Mult_start) begin
                        state <= BUSY;
                        cnt   <= LAT_CNT;
                    end
                end
                BUSY: begin
                    cnt <= cnt - ONE;
                    if (Flush || last) state <= IDLE;
                end
            endcase
        end
    end

    hilo_regs u_regs (
        .Clk     (Clk),
        .Reset   (Reset),
        .Hi_we   (move_ok && Mthi),
        .Lo_we   (move_ok && Mtlo),
        .Prod_we (prod_we),
        .Wdata   (Wdata),
        .Prod    (Mult_result),
        .Hi      (Hi),
        .Lo      (Lo)
    );

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed and random checks of hilo_unit at latencies
// 1 and 3 against a completion-time reference model.
module tb_hilo_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Is_signed;
    logic        Mthi;
    logic        Mtlo;
    logic [31:0] Wdata;
    logic        Mfhi;
    logic        Mflo;
    logic        Flush;
    logic [63:0] res_a;
    logic [63:0] res_b;

    logic        ms_a, sg_a, busy_a, stall_a;
    logic [31:0] hi_a, lo_a, rd_a;
    logic        ms_b, sg_b, busy_b, stall_b;
    logic [31:0] hi_b, lo_b, rd_b;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    hilo_unit #(.MULT_LATENCY(1)) dut_a (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Is_signed(Is_signed),
        .Mthi(Mthi), .Mtlo(Mtlo), .Wdata(Wdata), .Mfhi(Mfhi),
        .Mflo(Mflo), .Flush(Flush), .Mult_start(ms_a),
        .Mult_signed(sg_a), .Mult_result(res_a), .Hi(hi_a), .Lo(lo_a),
        .Rd_data(rd_a), .Busy(busy_a), .Stall(stall_a)
    );

    hilo_unit #(.MULT_LATENCY(3)) dut_b (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Is_signed(Is_signed),
        .Mthi(Mthi), .Mtlo(Mtlo), .Wdata(Wdata), .Mfhi(Mfhi),
        .Mflo(Mflo), .Flush(Flush), .Mult_start(ms_b),
        .Mult_signed(sg_b), .Mult_result(res_b), .Hi(hi_b), .Lo(lo_b),
        .Rd_data(rd_b), .Busy(busy_b), .Stall(stall_b)
    );

    logic [99:0] obs_a, obs_b;
    assign obs_a = {busy_a, stall_a, ms_a, sg_a, rd_a, hi_a, lo_a};
    assign obs_b = {busy_b, stall_b, ms_b, sg_b, rd_b, hi_b, lo_b};

    // Reference model: an accepted multiply completes at the end of
    // cycle issue+latency unless flushed or reset first.
    localparam int LAT[2] = '{1, 3};
    logic [31:0] m_hi[2]   = '{32'h0, 32'h0};
    logic [31:0] m_lo[2]   = '{32'h0, 32'h0};
    bit          m_inf[2]  = '{1'b0, 1'b0};
    int          m_done[2] = '{0, 0};
    int          cyc = 0;

    always @(posedge Clk) begin
        for (int k = 0; k < 2; k++) begin
            if (Reset) begin
                m_hi[k]  = 32'h0;
                m_lo[k]  = 32'h0;
                m_inf[k] = 1'b0;
            end else if (m_inf[k]) begin
                if (Flush) begin
                    m_inf[k] = 1'b0;
                end else if (cyc == m_done[k]) begin
                    {m_hi[k], m_lo[k]} = (k == 0) ? res_a : res_b;
                    m_inf[k] = 1'b0;
                end
            end else if (Start) begin
                if (!Flush) begin
                    m_inf[k]  = 1'b1;
                    m_done[k] = cyc + LAT[k];
                end
            end else begin
                if (Mthi) m_hi[k] = Wdata;
                if (Mtlo) m_lo[k] = Wdata;
            end
        end
        cyc++;
    end

    function automatic logic [99:0] exp_bundle(int k);
        logic [31:0] rd;
        logic        req;
        rd  = Mfhi ? m_hi[k] : (Mflo ? m_lo[k] : 32'h0);
        req = Mfhi | Mflo | Mthi | Mtlo | Start;
        return {m_inf[k], m_inf[k] & req, ~m_inf[k] & Start & ~Flush,
                Is_signed, rd, m_hi[k], m_lo[k]};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        Reset = 0; Start = 0; Is_signed = 0; Mthi = 0; Mtlo = 0;
        Wdata = 0; Mfhi = 0; Mflo = 0; Flush = 0;
    endtask

    task automatic drain(int n);
        clr();
        repeat (n) tick();
    endtask

    task automatic test_reset();
        clr();
        Reset = 1; Start = 1; Mthi = 1; Wdata = 32'h1234_5678;
        tick();
        tick();
        clr();
        Mfhi = 1;
        @(negedge Clk);
        checks++;
        if ({busy_a, stall_a, ms_a, rd_a, hi_a, lo_a} !== 99'h0) begin
            errors++;
            $display("FAIL reset_a got=%h want=0", obs_a);
        end
        checks++;
        if ({busy_b, stall_b, ms_b, rd_b, hi_b, lo_b} !== 99'h0) begin
            errors++;
            $display("FAIL reset_b got=%h want=0", obs_b);
        end
        tick();
    endtask

    task automatic test_mult_l1();
        clr();
        res_a = 64'h00000001_FFFFFFFE;
        res_b = {$urandom, $urandom};
        Start = 1;
        Is_signed = 1'($urandom);
        @(negedge Clk);
        checks++;
        if (ms_a !== 1'b1 || sg_a !== Is_signed) begin
            errors++;
            $display("FAIL l1_start got=%b%b want=1%b", ms_a, sg_a, Is_signed);
        end
        tick();
        Start = 0;
        @(negedge Clk);
        checks++;
        if (busy_a !== 1'b1 || ms_a !== 1'b0) begin
            errors++;
            $display("FAIL l1_busy got=%b%b want=10", busy_a, ms_a);
        end
        tick();
        Mfhi = 1;
        @(negedge Clk);
        checks++;
        if ({busy_a, hi_a, lo_a, rd_a} !== {1'b0, 32'h1, 32'hFFFFFFFE, 32'h1}) begin
            errors++;
            $display("FAIL l1_hilo got=%b %h %h %h want=0 1 fffffffe 1",
                     busy_a, hi_a, lo_a, rd_a);
        end
        drain(3);
    endtask

    task automatic test_stall_l3();
        logic [63:0] p;
        clr();
        p = {$urandom, $urandom};
        res_b = p;
        Start = 1;
        tick();
        Start = 0;
        Mflo = 1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge Clk);
            checks++;
            if (stall_b !== 1'b1 || busy_b !== 1'b1) begin
                errors++;
                $display("FAIL l3_stall T+%0d got=%b%b want=11", i, stall_b, busy_b);
            end
            tick();
        end
        @(negedge Clk);
        checks++;
        if ({stall_b, busy_b, rd_b, hi_b} !== {2'b00, p[31:0], p[63:32]}) begin
            errors++;
            $display("FAIL l3_read got=%b%b %h %h want=00 %h %h",
                     stall_b, busy_b, rd_b, hi_b, p[31:0], p[63:32]);
        end
        drain(2);
    endtask

    task automatic test_moves();
        logic [31:0] w;
        logic [31:0] lo_exp_a, lo_exp_b;
        clr();
        lo_exp_a = m_lo[0];
        lo_exp_b = m_lo[1];
        Mthi = 1;
        Wdata = 32'hDEADBEEF;
        tick();
        clr();
        Mfhi = 1;
        @(negedge Clk);
        checks++;
        if ({rd_a, rd_b, lo_a, lo_b} !==
            {32'hDEADBEEF, 32'hDEADBEEF, lo_exp_a, lo_exp_b}) begin
            errors++;
            $display("FAIL mthi got=%h %h %h %h want=deadbeef deadbeef %h %h",
                     rd_a, rd_b, lo_a, lo_b, lo_exp_a, lo_exp_b);
        end
        tick();
        w = $urandom;
        clr();
        Mtlo = 1;
        Wdata = w;
        tick();
        clr();
        Mflo = 1;
        @(negedge Clk);
        checks++;
        if ({rd_a, rd_b, hi_a, hi_b} !== {w, w, 32'hDEADBEEF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL mtlo got=%h %h %h %h want=%h %h deadbeef deadbeef",
                     rd_a, rd_b, hi_a, hi_b, w, w);
        end
        tick();
        clr();
    endtask

    task automatic test_flush();
        logic [31:0] ph, pl;
        clr();
        ph = m_hi[1];
        pl = m_lo[1];
        res_b = {~ph, ~pl};
        res_a = {$urandom, $urandom};
        Start = 1;
        tick();
        clr();
        tick();
        Flush = 1;
        @(negedge Clk);
        checks++;
        if (busy_b !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre got=%b want=1", busy_b);
        end
        tick();
        clr();
        for (int i = 3; i <= 4; i++) begin
            @(negedge Clk);
            checks++;
            if ({busy_b, hi_b, lo_b} !== {1'b0, ph, pl}) begin
                errors++;
                $display("FAIL flush T+%0d got=%b %h %h want=0 %h %h",
                         i, busy_b, hi_b, lo_b, ph, pl);
            end
            tick();
        end
    endtask

    task automatic test_flush_last();
        logic [31:0] ph, pl;
        clr();
        ph = m_hi[0];
        pl = m_lo[0];
        res_a = {~ph, ~pl};
        Start = 1;
        tick();
        clr();
        Flush = 1;
        tick();
        clr();
        @(negedge Clk);
        checks++;
        if ({busy_a, hi_a, lo_a} !== {1'b0, ph, pl}) begin
            errors++;
            $display("FAIL flush_last got=%b %h %h want=0 %h %h",
                     busy_a, hi_a, lo_a, ph, pl);
        end
        drain(1);
    endtask

    task automatic test_start_flush();
        clr();
        Start = 1;
        Flush = 1;
        @(negedge Clk);
        checks++;
        if ({ms_a, ms_b} !== 2'b00) begin
            errors++;
            $display("FAIL start_flush got=%b%b want=00", ms_a, ms_b);
        end
        tick();
        clr();
        @(negedge Clk);
        checks++;
        if ({busy_a, busy_b} !== 2'b00) begin
            errors++;
            $display("FAIL start_flush_busy got=%b%b want=00", busy_a, busy_b);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        clr();
        res_a = {$urandom | 32'h1, $urandom};
        res_b = {$urandom | 32'h1, $urandom};
        Start = 1;
        tick();
        clr();
        Reset = 1;
        tick();
        clr();
        for (int i = 2; i <= 4; i++) begin
            @(negedge Clk);
            checks++;
            if ({busy_a, hi_a, lo_a, busy_b, hi_b, lo_b} !== 130'h0) begin
                errors++;
                $display("FAIL reset_mid T+%0d got=%b %h %h %b %h %h want=0",
                         i, busy_a, hi_a, lo_a, busy_b, hi_b, lo_b);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        clr();
        Start = 1;
        @(negedge Clk);
        checks++;
        if (ms_b !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got=%b want=1", ms_b);
        end
        tick();
        for (int i = 1; i <= 3; i++) begin
            @(negedge Clk);
            checks++;
            if ({stall_b, ms_b} !== 2'b10) begin
                errors++;
                $display("FAIL b2b_hold T+%0d got=%b%b want=10", i, stall_b, ms_b);
            end
            tick();
        end
        @(negedge Clk);
        checks++;
        if ({stall_b, ms_b} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_issue got=%b%b want=01", stall_b, ms_b);
        end
        tick();
        drain(4);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            Reset     = ($urandom_range(0, 49) == 0);
            Flush     = ($urandom_range(0, 9) == 0);
            Start     = ($urandom_range(0, 3) == 0);
            Mthi      = ($urandom_range(0, 3) == 0);
            Mtlo      = ($urandom_range(0, 3) == 0);
            Mfhi      = 1'($urandom);
            Mflo      = 1'($urandom);
            Is_signed = 1'($urandom);
            Wdata     = $urandom;
            res_a     = {$urandom, $urandom};
            res_b     = {$urandom, $urandom};
            @(negedge Clk);
            checks++;
            if (obs_a !== exp_bundle(0)) begin
                errors++;
                $display("FAIL rand_a n=%0d got=%h want=%h", n, obs_a, exp_bundle(0));
            end
            checks++;
            if (obs_b !== exp_bundle(1)) begin
                errors++;
                $display("FAIL rand_b n=%0d got=%h want=%h", n, obs_b, exp_bundle(1));
            end
            tick();
        end
        clr();
    endtask

    initial begin
        clr();
        res_a = '0;
        res_b = '0;
        test_reset();
        test_mult_l1();
        test_stall_l3();
        test_moves();
        test_flush();
        test_flush_last();
        test_start_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
